// File: rtl/qam16_dump_slicer.sv
// Integrate-and-dump of the I/Q baseband products over one symbol,
// then a Gray-coded 16QAM slice of the dumped sums.
module qam16_dump_slicer #(
    parameter int SPS    = 16,
    parameter int ACC_W  = 16,
    parameter int THRESH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             in_valid,
    input  logic [7:0]       in_i,
    input  logic [7:0]       in_q,
    output logic             sym_valid,
    output logic [3:0]       sym_out,
    output logic [ACC_W-1:0] acc_i_out,
    output logic [ACC_W-1:0] acc_q_out,
    output logic             locked
);

    localparam int CNT_W = $clog2(SPS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

    typedef enum logic {IDLE, INTEG} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_i_q, acc_i_d;
    logic [ACC_W-1:0] acc_q_q, acc_q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sym_valid_q, sym_valid_d;
    logic [3:0]       sym_out_q, sym_out_d;
    logic [ACC_W-1:0] acc_i_out_q, acc_i_out_d;
    logic [ACC_W-1:0] acc_q_out_q, acc_q_out_d;
    logic             locked_q, locked_d;

    function automatic logic [ACC_W-1:0] sext(input logic [7:0] x);
        return {{(ACC_W-8){x[7]}}, x};
    endfunction

    // One extra bit catches overflow; clamp toward the sign of the true sum.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [7:0] x);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W-7){x[7]}}, x};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] s);
        if (s >= THR_P)
            return 2'b10;
        if (s >= 0)
            return 2'b11;
        if (s >= THR_N)
            return 2'b01;
        return 2'b00;
    endfunction

    logic [ACC_W-1:0] sum_i, sum_q;
    logic             dump;

    always_comb begin
        sum_i       = sat_add(acc_i_q, in_i);
        sum_q       = sat_add(acc_q_q, in_q);
        dump        = (state_q == INTEG) && in_valid && (cnt_q == LAST);
        state_d     = state_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        cnt_d       = cnt_q;
        sym_valid_d = 1'b0;
        sym_out_d   = sym_out_q;
        acc_i_out_d = acc_i_out_q;
        acc_q_out_d = acc_q_out_q;
        locked_d    = locked_q;

        if (dump) begin
            acc_i_out_d = sum_i;
            acc_q_out_d = sum_q;
            sym_out_d   = {slice(sum_i), slice(sum_q)};
            sym_valid_d = 1'b1;
        end

        // A sync sample starts a fresh window, even when it also closed one.
        if (sync) begin
            state_d  = INTEG;
            locked_d = 1'b1;
            acc_i_d  = in_valid ? sext(in_i) : '0;
            acc_q_d  = in_valid ? sext(in_q) : '0;
            cnt_d    = in_valid ? CNT_W'(1) : '0;
        end else if (dump) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (state_q == INTEG && in_valid) begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_out_q   <= '0;
            acc_i_out_q <= '0;
            acc_q_out_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_out_q   <= sym_out_d;
            acc_i_out_q <= acc_i_out_d;
            acc_q_out_q <= acc_q_out_d;
            locked_q    <= locked_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_out   = sym_out_q;
    assign acc_i_out = acc_i_out_q;
    assign acc_q_out = acc_q_out_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_qam16_dump_slicer.sv
// Directed and random checks of qam16_dump_slicer against a window-level
// arithmetic model; a second instance covers 12-bit saturation.
module tb_qam16_dump_slicer;

    localparam int SPS    = 16;
    localparam int THRESH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_i = '0;
    logic [7:0]  in_q = '0;

    logic        sym_valid;
    logic [3:0]  sym_out;
    logic [15:0] acc_i_out, acc_q_out;
    logic        locked;

    logic        b_sym_valid;
    logic [3:0]  b_sym_out;
    logic [11:0] b_acc_i, b_acc_q;
    logic        b_locked;

    qam16_dump_slicer #(.SPS(16), .ACC_W(16), .THRESH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
        .in_i(in_i), .in_q(in_q), .sym_valid(sym_valid),
        .sym_out(sym_out), .acc_i_out(acc_i_out),
        .acc_q_out(acc_q_out), .locked(locked)
    );

    qam16_dump_slicer #(.SPS(32), .ACC_W(12), .THRESH(1024)) dut_b (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
        .in_i(in_i), .in_q(in_q), .sym_valid(b_sym_valid),
        .sym_out(b_sym_out), .acc_i_out(b_acc_i),
        .acc_q_out(b_acc_q), .locked(b_locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Window-level model: samples since the last window start, sum per branch.
    bit   m_locked = 0;
    int   m_cnt = 0;
    int   m_si = 0, m_sq = 0;
    bit   m_vld = 0;
    logic [3:0] m_sym = '0;
    int   m_oi = 0, m_oq = 0;

    function automatic int sat16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic logic [1:0] code(input int s);
        if (s >= THRESH) return 2'b10;
        if (s >= 0) return 2'b11;
        if (s >= -THRESH) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit v,
                         input int i, input int q);
        bit closes;
        m_vld = 0;
        if (!r) begin
            m_locked = 0; m_cnt = 0; m_si = 0; m_sq = 0;
            m_sym = '0; m_oi = 0; m_oq = 0;
            return;
        end
        closes = m_locked && v && (m_cnt + 1 == SPS);
        if (closes) begin
            m_oi  = sat16(m_si + i);
            m_oq  = sat16(m_sq + q);
            m_sym = {code(m_oi), code(m_oq)};
            m_vld = 1;
            m_cnt = 0; m_si = 0; m_sq = 0;
        end
        if (s) begin
            m_locked = 1;
            m_cnt = v ? 1 : 0;
            m_si  = v ? i : 0;
            m_sq  = v ? q : 0;
        end else if (m_locked && v && !closes) begin
            m_cnt++;
            m_si = sat16(m_si + i);
            m_sq = sat16(m_sq + q);
        end
    endtask

    task automatic step(input bit s, input bit v, input int i, input int q,
                        input bit r = 1'b1);
        sync = s; in_valid = v; rst_n = r;
        in_i = 8'(i); in_q = 8'(q);
        @(posedge clk);
        model(r, s, v, i, q);
        #1;
        chk("sym_valid", 32'(sym_valid), 32'(m_vld));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sym_out", 32'(sym_out), 32'(m_sym));
        chk("acc_i_out", 32'($signed(acc_i_out)), 32'(m_oi));
        chk("acc_q_out", 32'($signed(acc_q_out)), 32'(m_oq));
    endtask

    task automatic window(input int i, input int q, input logic [3:0] sym,
                          input string tag);
        for (int k = 0; k < SPS; k++)
            step(1'b0, 1'b1, i, q);
        chk({tag, "_vld"}, 32'(sym_valid), 32'd1);
        chk({tag, "_sym"}, 32'(sym_out), 32'(sym));
    endtask

    initial begin
        int ri, rq;
        bit rs, rv;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_sym", 32'(sym_out), 32'd0);
        chk("rst_acc_i", 32'(acc_i_out), 32'd0);
        step(0, 1, 55, 55);
        chk("idle_ignored", 32'(sym_valid), 32'd0);

        // One window of (100,-20) starting at the sync sample.
        step(1, 1, 100, -20);
        for (int k = 0; k < SPS - 1; k++)
            step(0, 1, 100, -20);
        chk("t1_vld", 32'(sym_valid), 32'd1);
        chk("t1_acc_i", 32'($signed(acc_i_out)), 32'd1600);
        chk("t1_acc_q", 32'($signed(acc_q_out)), 32'hFFFF_FEC0);
        chk("t1_sym", 32'(sym_out), 32'b1001);

        window(-127, -127, 4'b0000, "w0");
        window(-10, 60, 4'b0111, "w1");
        window(0, 0, 4'b1111, "w2");
        window(127, 127, 4'b1010, "w3");

        // Alternating in_valid: dump after the 16th accepted sample.
        for (int k = 0; k < 2 * SPS - 1; k++)
            step(0, (k % 2) == 0, 50, -70);
        chk("tog_vld", 32'(sym_valid), 32'd1);
        chk("tog_acc_i", 32'($signed(acc_i_out)), 32'd800);
        chk("tog_sym", 32'(sym_out), 32'b1100);
        step(0, 0, 0, 0);

        // Partial window abandoned by sync after 7 samples.
        for (int k = 0; k < 7; k++)
            step(0, 1, 5, 5);
        step(1, 1, 100, 10);
        for (int k = 0; k < SPS - 1; k++)
            step(0, 1, 10, 10);
        chk("resync_acc_i", 32'($signed(acc_i_out)), 32'd250);
        chk("resync_sym", 32'(sym_out), 32'b1111);

        window(64, -64, 4'b1001, "thr");
        chk("thr_acc_q", 32'($signed(acc_q_out)), 32'hFFFF_FC00);
        window(63, -65, 4'b1100, "thr2");

        // Sync on the closing sample also opens the next window.
        for (int k = 0; k < SPS - 1; k++)
            step(0, 1, 1, 1);
        step(1, 1, 20, 20);
        chk("sd_acc_i", 32'($signed(acc_i_out)), 32'd35);
        for (int k = 0; k < SPS - 1; k++)
            step(0, 1, 2, 2);
        chk("sd_acc_i2", 32'($signed(acc_i_out)), 32'd50);

        // 12-bit instance saturates.
        step(0, 0, 0, 0, 0);
        step(1, 1, 127, -128);
        for (int k = 0; k < 31; k++) begin
            step(0, 1, 127, -128);
            if (k == 14)
                chk("b_mid_vld", 32'(b_sym_valid), 32'd0);
        end
        chk("b_vld", 32'(b_sym_valid), 32'd1);
        chk("b_acc_i", 32'(b_acc_i), 32'h7FF);
        chk("b_acc_q", 32'(b_acc_q), 32'h800);
        chk("b_sym", 32'(b_sym_out), 32'b1000);

        // Reset mid-window, then samples without sync.
        step(1, 1, 30, 30);
        for (int k = 0; k < 5; k++)
            step(0, 1, 30, 30);
        step(0, 1, 30, 30, 0);
        chk("mr_locked", 32'(locked), 32'd0);
        chk("mr_acc_q", 32'(acc_q_out), 32'd0);
        for (int k = 0; k < 20; k++)
            step(0, 1, 30, 30);

        for (int k = 0; k < 400; k++) begin
            rs = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ri = int'($urandom_range(0, 255)) - 128;
            rq = int'($urandom_range(0, 255)) - 128;
            step(rs, rv, ri, rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
